// File: rtl/rmst_arbiter.sv
// Arbitrates NUM_REQ buffers onto one AXI read master and routes the returned beats back.
// Optional macro RMST_ARB_FIXED_PRI_EN: fixed lowest-index priority instead of round-robin.
module rmst_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64,
  parameter int BURST_LENGTH = 4,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vec,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            done_vec,
  output logic [DATA_WIDTH-1:0]         s_tdata,
  output logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_ready,
  output logic                          m_req,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  input  logic                          m_done,
  input  logic [DATA_WIDTH-1:0]         m_tdata,
  input  logic                          m_valid,
  output logic                          m_ready,
  input  logic                          clear,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          err_beat,
  output logic                          err_ovf
);

  localparam int CNT_RAW = $clog2(BURST_LENGTH + 2);
  localparam int CNT_W   = (CNT_RAW < 3) ? 3 : ((CNT_RAW > 8) ? 8 : CNT_RAW);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]   addr_lat_q [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   req_addr_a [NUM_REQ];
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_plus;
  logic                    err_beat_q, err_beat_d;
  logic                    err_ovf_q, err_ovf_d;
  logic [NUM_REQ-1:0]      gnt_oh, inflight, accept, dup, set_new, cand;
  logic [ID_W-1:0]         winner;
  logic                    beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign req_addr_a[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  assign gnt_oh   = NUM_REQ'(1) << grant_q;
  assign inflight = (state_q != S_IDLE) ? gnt_oh : '0;
  assign accept   = clear ? '0 : req_vec;
  assign dup      = accept & (pending_q | inflight);
  assign set_new  = accept & ~(pending_q | inflight);
  assign cand     = pending_q | accept;

`ifdef RMST_ARB_FIXED_PRI_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // First set candidate at or after rr_ptr, wrapping past the top index.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_WAIT && m_done)
      rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    if (clear) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign beat     = m_valid & m_ready;
  assign cnt_plus = (beat && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    m_addr_d   = m_addr_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q | set_new;
    err_ovf_d  = err_ovf_q | (|dup);
    err_beat_d = err_beat_q;
    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          grant_d  = winner;
          m_addr_d = pending_q[winner] ? addr_lat_q[winner] : req_addr_a[winner];
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pending_d[grant_q] = 1'b0;
        state_d            = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_plus;
        if (m_done) begin
          if (cnt_plus != CNT_W'(BURST_LENGTH)) err_beat_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // clear drops queued work but lets an in-flight burst finish.
    if (clear) begin
      pending_d  = '0;
      err_beat_d = 1'b0;
      err_ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      grant_q    <= '0;
      m_addr_q   <= '0;
      cnt_q      <= '0;
      err_beat_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) addr_lat_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      m_addr_q   <= m_addr_d;
      cnt_q      <= cnt_d;
      err_beat_q <= err_beat_d;
      err_ovf_q  <= err_ovf_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (set_new[i]) addr_lat_q[i] <= req_addr_a[i];
      end
    end
  end

  always_comb begin
    s_valid  = '0;
    done_vec = '0;
    m_ready  = 1'b0;
    s_tdata  = '0;
    if (state_q == S_WAIT) begin
      s_valid  = {NUM_REQ{m_valid}} & gnt_oh;
      done_vec = {NUM_REQ{m_done}} & gnt_oh;
      m_ready  = |(s_ready & gnt_oh);
      s_tdata  = m_tdata;
    end
  end

  assign m_req    = (state_q == S_ISSUE);
  assign m_addr   = m_addr_q;
  assign busy     = (state_q != S_IDLE) | (|pending_q);
  assign grant_id = grant_q;
  assign err_beat = err_beat_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_rmst_arbiter.sv
// Directed bench for rmst_arbiter: grants, routing, backpressure, error flags, clear and reset.
module tb_rmst_arbiter;
  localparam int NR = 2;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vec;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   done_vec;
  logic [DW-1:0]   s_tdata;
  logic [NR-1:0]   s_valid;
  logic [NR-1:0]   s_ready;
  logic            m_req;
  logic [AW-1:0]   m_addr;
  logic            m_done;
  logic [DW-1:0]   m_tdata;
  logic            m_valid;
  logic            m_ready;
  logic            clear;
  logic            busy;
  logic [0:0]      grant_id;
  logic            err_beat;
  logic            err_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rmst_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LENGTH(BL)) dut (
    .clk(clk), .rst(rst), .req_vec(req_vec), .req_addr(req_addr), .done_vec(done_vec),
    .s_tdata(s_tdata), .s_valid(s_valid), .s_ready(s_ready), .m_req(m_req), .m_addr(m_addr),
    .m_done(m_done), .m_tdata(m_tdata), .m_valid(m_valid), .m_ready(m_ready), .clear(clear),
    .busy(busy), .grant_id(grant_id), .err_beat(err_beat), .err_ovf(err_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_vec = '0; req_addr = '0; s_ready = '1; m_done = 1'b0;
    m_tdata = '0; m_valid = 1'b0; clear = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic req(input logic [NR-1:0] v, input logic [63:0] a0, input logic [63:0] a1);
    req_vec  = v;
    req_addr = {a1, a0};
    step();
    req_vec = '0;
  endtask

  // Called in the cycle where m_req is expected; returns in the first WAIT cycle.
  task automatic issue_chk(input int id, input logic [63:0] addr);
    #1;
    chk("m_req_issue", 64'(m_req), 64'd1);
    chk("m_addr", m_addr, addr);
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("busy_issue", 64'(busy), 64'd1);
    step();
    req_vec = '0;
    #1;
    chk("m_req_wait", 64'(m_req), 64'd0);
  endtask

  // Drives nb beats (stall cycles of backpressure before beat 1), then m_done; returns in IDLE.
  task automatic burst(input int id, input int nb, input int stall, input bit merge);
    logic [NR-1:0] oh;
    logic [63:0]   dat;
    oh = NR'(1) << id;
    for (int b = 0; b < nb; b++) begin
      dat = 64'hDA7A_0000_0000_0000 | 64'(b) | (64'(id) << 16);
      if (b == 1) begin
        for (int s = 0; s < stall; s++) begin
          m_valid = 1'b1; m_tdata = {8{dat}}; s_ready = ~oh;
          #1;
          chk("stall_m_ready", 64'(m_ready), 64'd0);
          chk("stall_s_valid", 64'(s_valid), 64'(oh));
          step();
        end
      end
      s_ready = '1; m_valid = 1'b1; m_tdata = {8{dat}};
      m_done = merge && (b == nb - 1);
      #1;
      chk("beat_s_valid", 64'(s_valid), 64'(oh));
      chk("beat_m_ready", 64'(m_ready), 64'd1);
      chk("beat_s_tdata", s_tdata[63:0], dat);
      if (m_done) chk("done_vec_merged", 64'(done_vec), 64'(oh));
      step();
      m_valid = 1'b0; m_done = 1'b0;
    end
    if (!merge) begin
      m_done = 1'b1;
      #1;
      chk("done_vec", 64'(done_vec), 64'(oh));
      step();
      m_done = 1'b0;
    end
    #1;
    chk("m_req_idle", 64'(m_req), 64'd0);
    chk("done_vec_idle", 64'(done_vec), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset_dut();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_err_beat", 64'(err_beat), 64'd0);
    chk("rst_err_ovf", 64'(err_ovf), 64'd0);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);

    // Single request
    req(2'b01, 64'h1000, 64'h0);
    issue_chk(0, 64'h1000);
    burst(0, 4, 0, 1'b0);
    chk("single_busy_low", 64'(busy), 64'd0);
    chk("single_err_beat", 64'(err_beat), 64'd0);

    // Simultaneous requests, twice
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      req(2'b11, 64'h1000, 64'h2000);
      issue_chk(0, 64'h1000);
      burst(0, 4, 0, 1'b0);
      step();
      issue_chk(1, 64'h2000);
      burst(1, 4, 0, 1'b0);
    end
    // Buffer 0 re-requests right after its grant while buffer 1 waits
    req(2'b11, 64'h1000, 64'h2000);
    issue_chk(0, 64'h1000);
    burst(0, 4, 0, 1'b0);
    req(2'b01, 64'h3000, 64'h0);
`ifdef RMST_ARB_FIXED_PRI_EN
    issue_chk(0, 64'h3000);
    burst(0, 4, 0, 1'b0);
    step();
    issue_chk(1, 64'h2000);
    burst(1, 4, 0, 1'b0);
`else
    issue_chk(1, 64'h2000);
    burst(1, 4, 0, 1'b0);
    step();
    issue_chk(0, 64'h3000);
    burst(0, 4, 0, 1'b0);
`endif
    chk("rr_err_ovf", 64'(err_ovf), 64'd0);

    // Backpressure
    reset_dut();
    req(2'b10, 64'h0, 64'h2000);
    issue_chk(1, 64'h2000);
    burst(1, 4, 3, 1'b0);
    chk("bp_err_beat", 64'(err_beat), 64'd0);

    // Short burst, sticky flag, clear
    reset_dut();
    req(2'b01, 64'h4000, 64'h0);
    issue_chk(0, 64'h4000);
    burst(0, 3, 0, 1'b0);
    chk("short_err_beat", 64'(err_beat), 64'd1);
    step(); #1;
    chk("short_err_sticky", 64'(err_beat), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("short_err_cleared", 64'(err_beat), 64'd0);
    // Last beat and m_done in the same cycle still counts as a full burst
    req(2'b01, 64'h4100, 64'h0);
    issue_chk(0, 64'h4100);
    burst(0, 4, 0, 1'b1);
    chk("merge_err_beat", 64'(err_beat), 64'd0);

    // clear during WAIT with another request pending
    reset_dut();
    req(2'b10, 64'h0, 64'h2000);
    req_vec = 2'b01;
    req_addr[63:0] = 64'h5000;
    issue_chk(1, 64'h2000);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("clr_busy_wait", 64'(busy), 64'd1);
    burst(1, 4, 0, 1'b0);
    chk("clr_busy_after", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk("clr_no_m_req", 64'(m_req), 64'd0);
    end

    // Duplicate request before grant
    reset_dut();
    req(2'b10, 64'h0, 64'h2000);
    issue_chk(1, 64'h2000);
    req_vec = 2'b01; req_addr[63:0] = 64'h6000;
    step();
    req_vec = '0;
    #1;
    chk("dup_ovf_first", 64'(err_ovf), 64'd0);
    req_vec = 2'b01; req_addr[63:0] = 64'h7000;
    step();
    req_vec = '0;
    #1;
    chk("dup_ovf_second", 64'(err_ovf), 64'd1);
    burst(1, 4, 0, 1'b0);
    step();
    issue_chk(0, 64'h6000);
    burst(0, 4, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk("dup_single_m_req", 64'(m_req), 64'd0);
    end
    chk("dup_ovf_sticky", 64'(err_ovf), 64'd1);

    // Reset in the middle of a burst
    req(2'b01, 64'h8000, 64'h0);
    issue_chk(0, 64'h8000);
    m_valid = 1'b1; m_tdata = {8{64'h1234}};
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = 1'b1; m_done = 1'b1;
    #1;
    chk("mid_rst_done_vec", 64'(done_vec), 64'd0);
    chk("mid_rst_s_valid", 64'(s_valid), 64'd0);
    chk("mid_rst_m_ready", 64'(m_ready), 64'd0);
    chk("mid_rst_m_req", 64'(m_req), 64'd0);
    chk("mid_rst_m_addr", m_addr, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err_ovf", 64'(err_ovf), 64'd0);
    chk("mid_rst_s_tdata", s_tdata[63:0], 64'd0);
    step(); #1;
    chk("stray_done_vec", 64'(done_vec), 64'd0);
    chk("stray_err_beat", 64'(err_beat), 64'd0);
    m_done = 1'b0; m_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rmst_arbiter.md
Name: rmst_arbiter

Overview:
Shares the single AXI read master (rmst) between NUM_REQ switch buffers (input, weight, ... buffers).
- Each buffer issues a one-cycle read request with its computed address.
- The arbiter queues the request, grants one requester at a time and drives the master request and address.
- It routes the returned burst beats and the done pulse to the granted buffer only.
- It sits between the buffer array and the read-master engine in the conv accelerator top.

Parameters:
NUM_REQ, 2, number of requesting buffers (2..8)
DATA_WIDTH, 512, beat width
ADDR_WIDTH, 64, read address width
BURST_LENGTH, 4, beats expected per master transaction

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vec  in  NUM_REQ  per-buffer read request pulse (rmst_req)
req_addr  in  NUM_REQ*ADDR_WIDTH  per-buffer address; slice i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]; sampled in the req pulse cycle
done_vec  out  NUM_REQ  per-buffer done pulse
s_tdata  out  DATA_WIDTH  beat data, broadcast to all buffers
s_valid  out  NUM_REQ  per-buffer beat valid
s_ready  in  NUM_REQ  per-buffer ready
m_req  out  1  read-master request pulse
m_addr  out  ADDR_WIDTH  read-master address
m_done  in  1  read-master transaction done pulse
m_tdata  in  DATA_WIDTH  master beat data
m_valid  in  1  master beat valid
m_ready  out  1  master beat ready
clear  in  1  end of conv layer (end_conv)
busy  out  1  FSM not in IDLE, or any request pending
grant_id  out  clog2(NUM_REQ) (min 1)  current/last granted index
err_beat  out  1  sticky: m_done seen with beat count != BURST_LENGTH
err_ovf  out  1  sticky: req pulse from a requester already pending or in flight

Behaviour:
- Reset (sync, rst=1) clears:
  - all outputs to 0; m_addr=0; grant_id=0
  - pending[], addr latches and beat counter
  - round-robin pointer rr_ptr=0; FSM=IDLE
- Request capture:
  - req_vec[i]=1 sets pending[i] and latches addr_lat[i] from slice i.
  - If pending[i] is already set, or i is granted and not yet done: set err_ovf; keep the original address.
- FSM states:
  - IDLE: if any bit of (pending | req_vec) is set, pick a winner per the arbitration rule, set grant_id, load m_addr, go to ISSUE. A req pulse in cycle N produces m_req high in cycle N+1.
  - ISSUE: m_req=1 for exactly one cycle, clear pending[grant], go to WAIT.
  - WAIT: route beats; on m_done go to IDLE and advance rr_ptr to grant_id+1 (mod NUM_REQ).
- Routing (combinational, WAIT only; all zero elsewhere):
  - s_valid[g] = m_valid.
  - m_ready = s_ready[g].
  - s_tdata = m_tdata.
  - done_vec[g] = m_done.
- Beat counter (3..8 bits as needed):
  - Increments on m_valid & m_ready in WAIT; clears on entry to ISSUE.
  - On m_done, count != BURST_LENGTH sets err_beat. A beat and m_done in the same cycle count that beat first.
- m_done outside WAIT is ignored and routes nothing.
- Back-to-back grants: IDLE lasts one cycle minimum, so a minimum of 1 idle cycle separates m_done and the next m_req.
- clear:
  - Zeroes pending[], err_beat and err_ovf.
  - Does not abort an in-flight burst: WAIT completes normally and done_vec still pulses.
  - req_vec in the same cycle as clear is dropped.
  - rr_ptr resets to 0.
- rst mid-burst: immediate return to IDLE; later master beats/done are ignored until the next grant.
- Arbitration (default round-robin): first set bit at or after rr_ptr, searching upward with wrap.

Optional Feature:
RMST_ARB_FIXED_PRI_EN
- Defined: fixed priority, lowest index wins. rr_ptr logic is omitted and ignored.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
1. Single request: req_vec=2'b01, req_addr0=0x1000 in cycle 5 -> m_req=1 only in cycle 6 with m_addr=0x1000. Four beats pass to s_valid[0]; m_done -> done_vec=2'b01 the same cycle; busy falls the next cycle.
2. Simultaneous requests: req_vec=2'b11, addr0=0x1000, addr1=0x2000 -> grants 0 then 1 (m_addr 0x1000 then 0x2000). Repeat both -> order 0,1 again. Buffer 0 re-requesting during buffer 1's burst -> order 0,1,0, no starvation. With RMST_ARB_FIXED_PRI_EN, a continuous req0 starves req1.
3. Backpressure: s_ready[1]=0 for 3 cycles mid-burst -> m_ready=0 for those cycles; beat count ends at 4; err_beat=0.
4. Short burst: 3 beats then m_done -> err_beat=1 (sticky); clear -> err_beat=0.
5. clear in WAIT with req0 pending: current burst completes, done_vec pulses; pending request is dropped and no further m_req follows.
6. Duplicate request: req0 pulsed twice before grant -> err_ovf=1, one m_req with the first address. rst asserted mid-WAIT -> all outputs 0 next cycle; stray m_done produces no done_vec.
